// File: rtl/layer_sched.sv
// ---------------------------------------------------------------------------
// layer_sched
// Top-level sequencer for the CNN accelerator. It issues one-cycle start
// pulses to the datapath engines in a fixed order and waits for each engine's
// done pulse. The order is: input unshuffle; then weight load + conv for each
// layer-1 output-channel group; then the same for layer 2; then conv+pool.
// Weight and bias base addresses for the current group are produced from the
// group/layer counters.
//
// Optional feature: define LAYER_SCHED_WATCHDOG_EN to build a per-state
// watchdog. When a busy state lasts TIMEOUT cycles, err is set and the run is
// forced to DONE.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   enable                          start request, sampled only in IDLE
//   busy, valid                     high outside IDLE / one pulse at run end
//   unshuf_start/unshuf_done        unshuffle engine handshake
//   wload_start/wload_done          weight loader handshake
//   conv_start/conv_done            conv engine handshake
//   pool_start/pool_done            conv_pool engine handshake
//   layer, grp_idx                  current layer (0/1) and group index
//   w_base, b_base                  weight / bias SRAM base of current group
//   state_o                         state encoding for debug
//   err                             sticky error (stray done or watchdog)
// ---------------------------------------------------------------------------
module layer_sched #(
    parameter int L1_GROUPS = 3,
    parameter int L2_GROUPS = 3,
    parameter int W_PER_GRP = 16,
    parameter int B_PER_GRP = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       busy,
    output logic       valid,
    output logic       unshuf_start,
    input  logic       unshuf_done,
    output logic       wload_start,
    input  logic       wload_done,
    output logic       conv_start,
    input  logic       conv_done,
    output logic       pool_start,
    input  logic       pool_done,
    output logic       layer,
    output logic [3:0] grp_idx,
    output logic [9:0] w_base,
    output logic [5:0] b_base,
    output logic [2:0] state_o,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNSHUF = 3'd1,
        WLOAD  = 3'd2,
        CONV   = 3'd3,
        POOL   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] next_grp;
    logic       next_layer;
    logic       forced;
    logic       last_grp;
    logic       stray_done;
    logic       timeout_hit;

    logic       busy_d, valid_d, err_d;
    logic       unshuf_start_d, wload_start_d, conv_start_d, pool_start_d;
    logic [9:0] w_base_d;
    logic [5:0] b_base_d;
    logic       entering;
    int         slot;

    assign state_o  = state;
    assign last_grp = layer ? (grp_idx == 4'(L2_GROUPS - 1))
                            : (grp_idx == 4'(L1_GROUPS - 1));

    // Any done pulse that does not belong to the current state is an error.
    assign stray_done = (unshuf_done && state != UNSHUF) ||
                        (wload_done  && state != WLOAD)  ||
                        (conv_done   && state != CONV)   ||
                        (pool_done   && state != POOL);

`ifdef LAYER_SCHED_WATCHDOG_EN
    logic [15:0] wd_cnt;
    logic        wd_active;

    assign wd_active   = (state == UNSHUF) || (state == WLOAD) ||
                         (state == CONV)   || (state == POOL);
    // The counter reads 0 in the first cycle of a state, so the limit is hit
    // in the TIMEOUT-th cycle spent there.
    assign timeout_hit = wd_active && (wd_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (next_state != state) begin
            wd_cnt <= '0;
        end else if (wd_active) begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register plus all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            valid        <= 1'b0;
            unshuf_start <= 1'b0;
            wload_start  <= 1'b0;
            conv_start   <= 1'b0;
            pool_start   <= 1'b0;
            layer        <= 1'b0;
            grp_idx      <= '0;
            w_base       <= '0;
            b_base       <= '0;
            err          <= 1'b0;
        end else begin
            state        <= next_state;
            busy         <= busy_d;
            valid        <= valid_d;
            unshuf_start <= unshuf_start_d;
            wload_start  <= wload_start_d;
            conv_start   <= conv_start_d;
            pool_start   <= pool_start_d;
            layer        <= next_layer;
            grp_idx      <= next_grp;
            w_base       <= w_base_d;
            b_base       <= b_base_d;
            err          <= err_d;
        end
    end

    // Next state and next group/layer position.
    always_comb begin
        next_state = state;
        next_grp   = grp_idx;
        next_layer = layer;
        forced     = 1'b0;
        case (state)
            IDLE:   if (enable) next_state = UNSHUF;
            UNSHUF: if (unshuf_done) begin
                        next_state = WLOAD;
                        next_grp   = '0;
                        next_layer = 1'b0;
                    end
            WLOAD:  if (wload_done) next_state = CONV;
            CONV:   if (conv_done) begin
                        if (!last_grp) begin
                            next_state = WLOAD;
                            next_grp   = grp_idx + 4'd1;
                        end else if (!layer) begin
                            next_state = WLOAD;
                            next_grp   = '0;
                            next_layer = 1'b1;
                        end else begin
                            next_state = POOL;
                        end
                    end
            POOL:   if (pool_done) next_state = DONE;
            DONE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // A matching done wins over a watchdog expiry in the same cycle.
        if (timeout_hit && next_state == state) begin
            next_state = DONE;
            forced     = 1'b1;
        end
    end

    // Next values of the registered outputs; starts fire on state entry so
    // they land in the first cycle of the new state.
    always_comb begin
        entering       = (next_state != state);
        unshuf_start_d = entering && (next_state == UNSHUF);
        wload_start_d  = entering && (next_state == WLOAD);
        conv_start_d   = entering && (next_state == CONV);
        pool_start_d   = entering && (next_state == POOL);
        valid_d        = (next_state == DONE);
        busy_d         = (next_state != IDLE);
        err_d          = err || stray_done || forced;
        slot           = next_layer ? (L1_GROUPS + int'(next_grp)) : int'(next_grp);
        w_base_d       = 10'(slot * W_PER_GRP);
        b_base_d       = 6'(slot * B_PER_GRP);
    end

endmodule

// File: tb/tb_layer_sched.sv
// ---------------------------------------------------------------------------
// tb_layer_sched
// Self-checking bench for layer_sched (L1_GROUPS=3, L2_GROUPS=2). An engine
// responder answers every start with the matching done after a chosen or
// random gap. The expected start order and addresses come from a plan list
// built from the group counts; timing checks use absolute cycle numbers.
// ---------------------------------------------------------------------------
module tb_layer_sched;

    localparam int L1  = 3;
    localparam int L2  = 2;
    localparam int WPG = 16;
    localparam int BPG = 4;
    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       unshuf_done = 1'b0, wload_done = 1'b0, conv_done = 1'b0, pool_done = 1'b0;
    logic       busy, valid, unshuf_start, wload_start, conv_start, pool_start;
    logic       layer, err;
    logic [3:0] grp_idx;
    logic [9:0] w_base;
    logic [5:0] b_base;
    logic [2:0] state_o;

    layer_sched #(
        .L1_GROUPS(L1), .L2_GROUPS(L2), .W_PER_GRP(WPG), .B_PER_GRP(BPG), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .busy(busy), .valid(valid),
        .unshuf_start(unshuf_start), .unshuf_done(unshuf_done),
        .wload_start(wload_start), .wload_done(wload_done),
        .conv_start(conv_start), .conv_done(conv_done),
        .pool_start(pool_start), .pool_done(pool_done),
        .layer(layer), .grp_idx(grp_idx), .w_base(w_base), .b_base(b_base),
        .state_o(state_o), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 unshuf, 1 wload, 2 conv, 3 pool
        int lay;
        int grp;
        int wb;
        int bb;
    } step_t;

    step_t plan[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    lastValid = -1;
    int    lastEn = -1;
    bit    expErr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Whole-network schedule: unshuffle, wload/conv per group per layer, pool.
    function automatic void buildPlan();
        step_t s;
        plan.delete();
        s = '{0, 0, 0, 0, 0};
        plan.push_back(s);
        for (int l = 0; l < 2; l++) begin
            for (int g = 0; g < (l == 0 ? L1 : L2); g++) begin
                int slot = (l == 0) ? g : L1 + g;
                s = '{1, l, g, slot * WPG, slot * BPG};
                plan.push_back(s);
                s.kind = 2;
                plan.push_back(s);
            end
        end
        s = '{3, 0, 0, 0, 0};
        plan.push_back(s);
    endfunction

    task automatic checkAllZero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_starts"}, {unshuf_start, wload_start, conv_start, pool_start}, 0);
        chk({tag, "_layer"}, layer, 0);
        chk({tag, "_grp"}, grp_idx, 0);
        chk({tag, "_wbase"}, w_base, 0);
        chk({tag, "_bbase"}, b_base, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_state"}, state_o, 0);
    endtask

    // Entered at the sampling point of an IDLE cycle. Drives enable, answers
    // each start after a gap in [gapMin,gapMax] and checks order, addresses
    // and timing. abortL2 pulls rst_n low when the first layer-2 conv starts.
    task automatic applyStimulus(input int gapMin, input int gapMax, input bit holdEn,
                                 input bit keepAfter, input bit randEn, input bit spurious,
                                 input bit abortL2);
        int pos = 0, cnt = 0, pend = -1, doneCyc = -1, spurCyc = -1, budget = 0, kind;
        bit finished = 1'b0;
        logic [3:0] sv;
        lastEn = cyc;
        enable = 1'b1;
        while (!finished && budget < 600) begin
            tick();
            budget++;
            {unshuf_done, wload_done, conv_done, pool_done} = 4'b0;
            enable = holdEn ? 1'b1 : (randEn ? 1'($urandom_range(0, 1)) : 1'b0);
            chk("busy_run", busy, 1);
            if (spurCyc >= 0 && cyc == spurCyc + 1) begin
                chk("spur_state", state_o, 2);
                chk("spur_err", err, 1);
            end
            sv = {unshuf_start, wload_start, conv_start, pool_start};
            if (sv != 4'b0) begin
                chk("one_start", $countones(sv), 1);
                kind = unshuf_start ? 0 : wload_start ? 1 : conv_start ? 2 : 3;
                chk("start_kind", kind, pos < plan.size() ? plan[pos].kind : -1);
                if (pos < plan.size()) begin
                    if (kind == 1 || kind == 2) begin
                        chk("layer", layer, plan[pos].lay);
                        chk("grp_idx", grp_idx, plan[pos].grp);
                        chk("w_base", w_base, plan[pos].wb);
                        chk("b_base", b_base, plan[pos].bb);
                    end
                    if (pos == 0) chk("unshuf_latency", cyc - lastEn, 1);
                    else chk("done_to_start", cyc - doneCyc, 1);
                    if (abortL2 && kind == 2 && plan[pos].lay == 1) begin
                        rst_n = 1'b0;
                        enable = 1'b0;
                        return;
                    end
                    if (spurious && spurCyc < 0 && kind == 1) begin
                        conv_done = 1'b1;
                        spurCyc = cyc;
                    end
                end
                pend = kind;
                cnt = $urandom_range(gapMax, gapMin);
                pos++;
            end else if (pend >= 0) begin
                if (cnt == 0) begin
                    case (pend)
                        0: unshuf_done = 1'b1;
                        1: wload_done = 1'b1;
                        2: conv_done = 1'b1;
                        default: pool_done = 1'b1;
                    endcase
                    doneCyc = cyc;
                    pend = -1;
                end else begin
                    cnt--;
                end
            end
            if (valid) begin
                chk("valid_latency", cyc - doneCyc, 1);
                chk("plan_complete", pos, plan.size());
                chk("done_state", state_o, 5);
                chk("err_at_end", err, expErr);
                lastValid = cyc;
                finished = 1'b1;
            end
        end
        chk("run_finished", finished, 1);
        tick();
        {unshuf_done, wload_done, conv_done, pool_done} = 4'b0;
        enable = keepAfter;
        chk("busy_after", busy, 0);
        chk("valid_single", valid, 0);
        chk("idle_after", state_o, 0);
    endtask

    // Checks the cycle count of a zero-gap run: two cycles per stage plus DONE.
    task automatic checkOutput(input int stages);
        chk("zero_gap_length", lastValid - lastEn, 2 * stages + 1);
    endtask

    initial begin
        int v1;
        buildPlan();
        tick();
        tick();
        checkAllZero("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", state_o, 0);

        $display("[TB] nominal run, 5-cycle done latency");
        applyStimulus(4, 4, 0, 0, 0, 0, 0);

        $display("[TB] zero-gap handshake");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput(plan.size());
        chk("zero_gap_err", err, 0);

        $display("[TB] spurious conv_done in WLOAD");
        expErr = 1'b1;
        applyStimulus(0, 3, 0, 0, 0, 1, 0);
        chk("err_sticky", err, 1);

        $display("[TB] mid-run reset in layer-2 conv");
        applyStimulus(0, 2, 0, 0, 0, 0, 1);
        tick();
        rst_n = 1'b1;
        checkAllZero("midreset");
        tick();
        chk("no_start_after_reset", {unshuf_start, wload_start, conv_start, pool_start}, 0);
        chk("idle_after_midreset", state_o, 0);
        expErr = 1'b0;
        applyStimulus(0, 2, 0, 0, 0, 0, 0);

        $display("[TB] enable held high, back-to-back runs");
        applyStimulus(1, 3, 1, 1, 0, 0, 0);
        v1 = lastValid;
        applyStimulus(1, 3, 1, 0, 0, 0, 0);
        chk("b2b_first_start", lastEn - v1, 1);

        $display("[TB] random gaps with enable toggling while busy");
        for (int r = 0; r < 3; r++) begin
            applyStimulus(0, 6, 0, 0, 1, 0, 0);
        end

`ifdef LAYER_SCHED_WATCHDOG_EN
        begin
            int e = -1, vcyc = -1;
            $display("[TB] watchdog, wload_done withheld");
            enable = 1'b1;
            tick();
            enable = 1'b0;
            chk("wd_unshuf_start", unshuf_start, 1);
            unshuf_done = 1'b1;
            tick();
            unshuf_done = 1'b0;
            chk("wd_wload_start", wload_start, 1);
            e = cyc;
            for (int i = 0; i < 40 && vcyc < 0; i++) begin
                tick();
                if (valid) vcyc = cyc;
            end
            chk("wd_valid_cycle", vcyc - e, TMO);
            chk("wd_err", err, 1);
            tick();
            chk("wd_idle", state_o, 0);
            chk("wd_valid_single", valid, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_sched.md
Name: layer_sched

Overview:
Top-level sequencer for the CNN accelerator. Issues start pulses to the datapath engines in a fixed order and collects their done pulses: input unshuffle, then weight load and conv for each layer-1 output-channel group, then the same for layer 2, then conv+pool. Weight and bias base addresses for each group come from internal counters. Replaces the ad-hoc FSM in the accelerator top level with one reusable, checkable control block.

Parameters:
L1_GROUPS, 3, output-channel groups in layer 1 (>=1)
L2_GROUPS, 3, output-channel groups in layer 2 (>=1)
W_PER_GRP, 16, weight SRAM words per group
B_PER_GRP, 4, bias SRAM words per group
TIMEOUT, 4096, watchdog limit in cycles (used only with the watchdog macro)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous, active-low reset
enable  input  1  start request; sampled only in IDLE
busy  output  1  high in every state except IDLE
valid  output  1  one-cycle pulse when the whole network finishes
unshuf_start  output  1  one-cycle pulse to the unshuffle engine
unshuf_done  input  1  one-cycle pulse from the unshuffle engine
wload_start  output  1  one-cycle pulse to the weight loader
wload_done  input  1  one-cycle pulse from the weight loader
conv_start  output  1  one-cycle pulse to the conv engine
conv_done  input  1  one-cycle pulse from the conv engine
pool_start  output  1  one-cycle pulse to the conv_pool engine
pool_done  input  1  one-cycle pulse from the conv_pool engine
layer  output  1  0 = layer 1, 1 = layer 2; held stable during WLOAD and CONV
grp_idx  output  4  current group index within the layer
w_base  output  10  weight base address = (layer ? L1_GROUPS+grp_idx : grp_idx) * W_PER_GRP
b_base  output  6  bias base address, same formula with B_PER_GRP
state_o  output  3  current state encoding, for debug
err  output  1  sticky error flag

Behaviour:
- Reset: state IDLE. All outputs 0: busy, valid, every *_start, layer, grp_idx, w_base, b_base, err.
- States: IDLE=0, UNSHUF=1, WLOAD=2, CONV=3, POOL=4, DONE=5.
- Transitions:
  - IDLE -> UNSHUF when enable=1.
  - UNSHUF -> WLOAD on unshuf_done; grp_idx=0, layer=0.
  - WLOAD -> CONV on wload_done.
  - CONV -> WLOAD on conv_done when the layer has groups left; grp_idx increments.
  - CONV -> WLOAD on conv_done at the last layer-1 group (grp_idx = L1_GROUPS-1); layer becomes 1, grp_idx becomes 0.
  - CONV -> POOL on conv_done at the last layer-2 group.
  - POOL -> DONE on pool_done.
  - DONE -> IDLE unconditionally after 1 cycle.
- Start pulses are registered. Each is high exactly in the first cycle of its state, so a done in cycle k puts the next start in cycle k+1. Minimum latency from done to the next start is 1 cycle.
- valid is registered and high in the single DONE cycle. busy is 0 in IDLE only.
- w_base and b_base are registered and update in the same cycle as grp_idx/layer. They are stable from the cycle wload_start is high until the state leaves CONV.
- Done inputs are honoured only in their matching state. A done received in any other state is ignored and sets err, which holds until reset. More than one done pulse in the same cycle: the one matching the state is honoured and the others set err.
- enable outside IDLE is ignored and does not set err. enable held high continuously causes back-to-back runs: DONE -> IDLE -> UNSHUF.
- Reset asserted mid-operation returns to IDLE within 1 cycle. No start pulse is issued in the reset cycle or the cycle after it.
- grp_idx never exceeds max(L1_GROUPS, L2_GROUPS)-1. The address products are truncated to port width; the parameters are chosen so no overflow occurs.

Optional Feature:
LAYER_SCHED_WATCHDOG_EN
- Defined: a 16-bit counter clears on each state entry and increments every cycle spent in UNSHUF, WLOAD, CONV or POOL. When it reaches TIMEOUT, err sets and the FSM forces DONE: valid pulses, then IDLE.
- Undefined: no counter is built; the FSM waits indefinitely for done pulses.

Test Plan (L1_GROUPS=3, L2_GROUPS=2, W_PER_GRP=16, B_PER_GRP=4):
- Nominal run: enable pulse; each done returned 5 cycles after its start -> start sequence is unshuf, then wload/conv x5, then pool. w_base sequence 0,16,32,48,64; b_base 0,4,8,12,16; layer flips to 1 at the 4th wload; exactly one valid pulse; busy falls the cycle after valid.
- Zero-gap handshake: each done returned the cycle immediately after its start -> next start arrives 1 cycle after each done; total run length is deterministic; err=0.
- Spurious done: conv_done pulse while in WLOAD -> state unchanged, err=1 and stays 1, run completes normally.
- Mid-run reset: rst_n low for 1 cycle during layer-2 CONV -> all outputs 0, state_o=0, no start pulse in the 2 cycles after reset; a fresh enable then runs correctly from grp_idx 0, layer 0.
- Enable held high: two full runs back-to-back -> two valid pulses 1 IDLE cycle apart; enable pulses during busy are ignored.
- Watchdog (macro defined, TIMEOUT=20): withhold wload_done -> err=1 after 20 cycles in WLOAD, valid pulses once, FSM returns to IDLE.
